uart_tx_9600: RTL and testbench

UART_TX_9600 -- requirements
Module: uart_tx_9600

---
 rtl/uart_tx_9600.sv | 136 +++++++++++++
 tb/tb_uart_tx_9600.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_9600.sv
// 8N1/8E1 UART transmitter, one start bit, LSB-first data, STOP_BITS stop bits.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_9600 #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       busy
);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    localparam logic [15:0] LAST_CNT  = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  LAST_STOP = 3'(STOP_BITS - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shreg_q, shreg_d;
    logic        tx_q, tx_d;
    logic [1:0]  sync_q;
    logic        rst_ok;
    logic        bit_end;

    // Accepts are held off until the released reset has crossed two flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], 1'b1};
        end
    end

    assign rst_ok  = sync_q[1];
    assign bit_end = (cnt_q == LAST_CNT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 16'd0;
            idx_q   <= 3'd0;
            shreg_q <= 8'd0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
        end
    end

    // tx is registered from the current state, so the line lags the FSM by one cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 16'd1;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        tx_d    = 1'b1;
        unique case (state_q)
            IDLE: begin
                cnt_d = 16'd0;
                idx_d = 3'd0;
                if (tx_valid && rst_ok) begin
                    state_d = START;
                    shreg_d = tx_data;
                end
            end
            START: begin
                tx_d = 1'b0;
                if (bit_end) begin
                    state_d = DATA;
                    cnt_d   = 16'd0;
                    idx_d   = 3'd0;
                end
            end
            DATA: begin
                tx_d = shreg_q[idx_q];
                if (bit_end) begin
                    cnt_d = 16'd0;
                    if (idx_q == 3'd7) begin
                        idx_d = 3'd0;
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                tx_d = ^shreg_q;
                if (bit_end) begin
                    state_d = STOP;
                    cnt_d   = 16'd0;
                    idx_d   = 3'd0;
                end
            end
`endif
            STOP: begin
                tx_d = 1'b1;
                if (bit_end) begin
                    cnt_d = 16'd0;
                    if (idx_q == LAST_STOP) begin
                        state_d = IDLE;
                        idx_d   = 3'd0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 16'd0;
                idx_d   = 3'd0;
            end
        endcase
    end

    assign tx_ready = (state_q == IDLE);
    assign busy     = ~tx_ready;
    assign tx       = tx_q;

endmodule

// File: tb/tb_uart_tx_9600.sv
// Self-checking bench for uart_tx_9600: table-driven frames, scoreboard-decoded line,
// plus hand sequences for reset sync, back-to-back, ignored valid, abort and 2 stop bits.
module tb_uart_tx_9600;

`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int CPB   = 4;
    localparam int NB    = 10 + P;
    localparam int FRAME = NB * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx, busy;

    logic [7:0] tx_data2 = 8'h00;
    logic       tx_valid2 = 1'b0;
    logic       tx_ready2, tx2, busy2;

    uart_tx_9600 #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx(tx), .busy(busy)
    );

    uart_tx_9600 #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst(rst), .tx_data(tx_data2), .tx_valid(tx_valid2),
        .tx_ready(tx_ready2), .tx(tx2), .busy(busy2)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] sb[$];
    bit   mon_en = 1'b1;
    logic last_par = 1'b0;

    typedef struct {
        logic [7:0] data;
        logic       par;
    } vec_t;
    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] d, input bit push, output bit ok);
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (busy) ok = 1'b1;
        end
        tx_valid = 1'b0;
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
        else if (push) sb.push_back(d);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 500) begin
            n++;
            @(negedge clk);
        end
        if (busy) check("idle_timeout", 32'd1, 32'd0);
    endtask

    // Line monitor: decodes every frame and compares it against the scoreboard.
    initial begin
        logic [15:0] mbits;
        logic        first;
        bit          hold_ok;
        logic [7:0]  exp;
        forever begin
            @(negedge clk);
            if (mon_en && rst && tx == 1'b0) begin
                mbits = 16'd0;
                for (int b = 0; b < NB; b++) begin
                    hold_ok = 1'b1;
                    first = tx;
                    for (int k = 0; k < CPB; k++) begin
                        if (!(b == 0 && k == 0)) @(negedge clk);
                        if (k == 0) first = tx;
                        else if (tx !== first) hold_ok = 1'b0;
                    end
                    mbits[b] = first;
                    check("bit_hold", {31'd0, hold_ok}, 32'd1);
                end
                if (sb.size() == 0) begin
                    check("unexpected_frame", 32'd0, 32'd1);
                end else begin
                    exp = sb.pop_front();
                    check("rx_data", {24'd0, mbits[8:1]}, {24'd0, exp});
                    check("stop_bit", {31'd0, mbits[NB-1]}, 32'd1);
`ifdef UART_TX_PARITY_EN
                    last_par = mbits[9];
                    check("parity_model", {31'd0, mbits[9]}, {31'd0, ^exp});
`endif
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   ok;
        int   n, n1, gap, stophi;
        bit   hi;
        logic s[64];
        logic [7:0] rx;
        logic b_a, b_b, rdy;
        int   l2;

        vecs[0] = '{8'hA7, 1'b1};
        vecs[1] = '{8'h00, 1'b0};
        vecs[2] = '{8'hFF, 1'b0};
        vecs[3] = '{8'h3C, 1'b0};
        vecs[4] = '{8'h5A, 1'b0};
        vecs[5] = '{8'h01, 1'b1};

        // Reset with no clock edge in between.
        #1 rst = 1'b0;
        #2;
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_ready", {31'd0, tx_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        check("rst_tx_clk", {31'd0, tx}, 32'd1);

        // Release: accept only on the third edge.
        rst      = 1'b1;
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        @(negedge clk);
        check("sync_edge1", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("sync_edge2", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("accept_edge3", {31'd0, busy}, 32'd1);
        if (busy) sb.push_back(8'h55);
        tx_valid = 1'b0;
        wait_idle(n);
        check("busy_len_55", n, FRAME);
        check("ready_after_55", {31'd0, tx_ready}, 32'd1);
        repeat (2) @(negedge clk);

        foreach (vecs[i]) begin
            send(vecs[i].data, 1'b1, ok);
            wait_idle(n);
            check("frame_len", n, FRAME);
            repeat (2) @(negedge clk);
`ifdef UART_TX_PARITY_EN
            check("parity_table", {31'd0, last_par}, {31'd0, vecs[i].par});
`endif
        end

        // Back-to-back with tx_valid held; data changes right after accept.
        @(negedge clk);
        tx_data  = 8'h01;
        tx_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (busy) ok = 1'b1;
        end
        check("b2b_accept1", {31'd0, ok}, 32'd1);
        if (ok) sb.push_back(8'h01);
        tx_data = 8'h80;
        wait_idle(n1);
        check("b2b_len1", n1, FRAME);
        gap = 0;
        while (!busy && gap < 10) begin
            gap++;
            @(negedge clk);
        end
        check("b2b_gap", gap, 1);
        if (busy) sb.push_back(8'h80);
        tx_valid = 1'b0;
        wait_idle(n);
        check("b2b_len2", n, FRAME);
        repeat (2) @(negedge clk);

        // tx_valid pulse mid-frame must be ignored.
        send(8'h00, 1'b1, ok);
        repeat (10) @(negedge clk);
        tx_data  = 8'hFF;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        wait_idle(n);
        check("ign_len", n + 11, FRAME);
        n = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (busy) n++;
        end
        check("ign_no_frame", n, 0);

        // Reset during data bit 3 aborts asynchronously.
        mon_en = 1'b0;
        send(8'hA5, 1'b0, ok);
        repeat (18) @(negedge clk);
        check("abort_bit3", {31'd0, tx}, 32'd0);
        #1 rst = 1'b0;
        #1;
        check("abort_tx", {31'd0, tx}, 32'd1);
        check("abort_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        hi = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) hi = 1'b0;
        end
        check("abort_stays_high", {31'd0, hi}, 32'd1);
        mon_en = 1'b1;

        // Two stop bits on the second instance.
        l2 = FRAME + CPB;
        @(negedge clk);
        tx_data2  = 8'h3C;
        tx_valid2 = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (busy2) ok = 1'b1;
        end
        tx_valid2 = 1'b0;
        check("s2_accept", {31'd0, ok}, 32'd1);
        b_a = 1'b0;
        b_b = 1'b1;
        rdy = 1'b0;
        for (int i = 0; i < l2; i++) begin
            @(negedge clk);
            s[i] = tx2;
            if (i == l2 - 2) b_a = busy2;
            if (i == l2 - 1) begin
                b_b = busy2;
                rdy = tx_ready2;
            end
        end
        for (int b = 0; b < 8; b++) rx[b] = s[CPB + CPB * b + 1];
        check("s2_start", {31'd0, s[0] | s[3]}, 32'd0);
        check("s2_data", {24'd0, rx}, 32'h3C);
        check("s2_pre_stop", {31'd0, s[l2-9]}, 32'd0);
        stophi = 0;
        for (int i = l2 - 8; i < l2; i++) if (s[i] === 1'b1) stophi++;
        check("s2_stop_len", stophi, 8);
        check("s2_busy_in_stop", {31'd0, b_a}, 32'd1);
        check("s2_busy_after", {31'd0, b_b}, 32'd0);
        check("s2_ready_after", {31'd0, rdy}, 32'd1);

        repeat (5) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
